algo_4cor1a_c40_t1_mem_resp: RTL and testbench

Behavioural responder for the T1 physical memory behind the 4cor1a_c40 counter algorithm. It is the memory end of the `t1_*` interface: it accepts per-bank writes on port A and reads on port B from the algorithm core and returns read data after a fixed pipeline latency. It instantiates as the T1 macro stand-in in simulation and formal builds. The assertion wrapper observes the same interface, so the two must agree cycle-for-cycle.

---
 rtl/algo_4cor1a_c40_t1_mem_resp_if.sv | 26 ++
 rtl/algo_4cor1a_c40_t1_mem_resp.sv | 97 +++++++++
 tb/tb_algo_4cor1a_c40_t1_mem_resp.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/algo_4cor1a_c40_t1_mem_resp_if.sv
// T1 memory bus between the 4cor1a_c40 counter core (master) and the T1 memory (slave).
// Each bank occupies slice i of every per-bank vector.
interface algo_4cor1a_c40_t1_mem_resp_if #(
    parameter int NUMCTPT    = 4,
    parameter int T1_BITSROW = 11,
    parameter int T1_PHYWDTH = 73
);
    logic [NUMCTPT-1:0]            t1_writeA;
    logic [NUMCTPT*T1_BITSROW-1:0] t1_addrA;
    logic [NUMCTPT*T1_PHYWDTH-1:0] t1_dinA;
    logic [NUMCTPT*T1_PHYWDTH-1:0] t1_bwA;
    logic [NUMCTPT-1:0]            t1_readB;
    logic [NUMCTPT*T1_BITSROW-1:0] t1_addrB;
    logic [NUMCTPT*T1_PHYWDTH-1:0] t1_doutB;
    logic [NUMCTPT-1:0]            t1_vldB;

    modport master (
        output t1_writeA, t1_addrA, t1_dinA, t1_bwA, t1_readB, t1_addrB,
        input  t1_doutB, t1_vldB
    );

    modport slave (
        input  t1_writeA, t1_addrA, t1_dinA, t1_bwA, t1_readB, t1_addrB,
        output t1_doutB, t1_vldB
    );
endinterface

// File: rtl/algo_4cor1a_c40_t1_mem_resp.sv
// Behavioural T1 memory responder: independent banks, masked writes, fixed-latency reads.
// Optional macro ALGO_4COR1A_C40_T1_INIT_EN adds per-row written flags for X-free reads.
module algo_4cor1a_c40_t1_mem_resp #(
    parameter int NUMCTPT    = 4,
    parameter int T1_NUMSROW = 2048,
    parameter int T1_BITSROW = 11,
    parameter int T1_PHYWDTH = 73,
    parameter int T1_DELAY   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    algo_4cor1a_c40_t1_mem_resp_if.slave   t1
);

    logic [NUMCTPT*T1_PHYWDTH-1:0] w_dout_all;
    logic [NUMCTPT-1:0]            w_vld_all;

    for (genvar gi = 0; gi < NUMCTPT; gi++) begin : g_bank
        logic [T1_PHYWDTH-1:0] r_mem [0:T1_NUMSROW-1];
        logic [T1_PHYWDTH-1:0] r_pipe_data [0:T1_DELAY-1];
        logic [T1_DELAY-1:0]   r_pipe_vld;
        logic [T1_PHYWDTH-1:0] r_dout;
        logic                  r_vld;

        logic                  w_we;
        logic                  w_re;
        logic [T1_BITSROW-1:0] w_addr_a;
        logic [T1_BITSROW-1:0] w_addr_b;
        logic [T1_PHYWDTH-1:0] w_din;
        logic [T1_PHYWDTH-1:0] w_bw;
        logic [T1_PHYWDTH-1:0] w_old;
        logic [T1_PHYWDTH-1:0] w_rd;

        assign w_we     = t1.t1_writeA[gi];
        assign w_re     = t1.t1_readB[gi];
        assign w_addr_a = t1.t1_addrA[gi*T1_BITSROW +: T1_BITSROW];
        assign w_addr_b = t1.t1_addrB[gi*T1_BITSROW +: T1_BITSROW];
        assign w_din    = t1.t1_dinA[gi*T1_PHYWDTH +: T1_PHYWDTH];
        assign w_bw     = t1.t1_bwA[gi*T1_PHYWDTH +: T1_PHYWDTH];

`ifdef ALGO_4COR1A_C40_T1_INIT_EN
        // An unwritten row behaves as all zeros, so its first masked write merges against 0.
        logic [T1_NUMSROW-1:0] r_wr_flag;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_wr_flag <= '0;
            end else if (w_we && (|w_bw)) begin
                r_wr_flag[w_addr_a] <= 1'b1;
            end
        end

        assign w_old = r_wr_flag[w_addr_a] ? r_mem[w_addr_a] : '0;
        assign w_rd  = r_wr_flag[w_addr_b] ? r_mem[w_addr_b] : '0;
`else
        assign w_old = r_mem[w_addr_a];
        assign w_rd  = r_mem[w_addr_b];
`endif

        // Non-blocking update gives read-before-write on a same-row collision.
        always_ff @(posedge clk) begin
            if (rst && w_we && (|w_bw)) begin
                r_mem[w_addr_a] <= (w_old & ~w_bw) | (w_din & w_bw);
            end
        end

        always_ff @(posedge clk) begin
            if (w_re) begin
                r_pipe_data[0] <= w_rd;
            end
            for (int k = 1; k < T1_DELAY; k++) begin
                r_pipe_data[k] <= r_pipe_data[k-1];
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_pipe_vld <= '0;
                r_vld      <= 1'b0;
                r_dout     <= '0;
            end else begin
                r_pipe_vld <= (r_pipe_vld << 1) | T1_DELAY'(w_re);
                r_vld      <= r_pipe_vld[T1_DELAY-1];
                if (r_pipe_vld[T1_DELAY-1]) begin
                    r_dout <= r_pipe_data[T1_DELAY-1];
                end
            end
        end

        assign w_dout_all[gi*T1_PHYWDTH +: T1_PHYWDTH] = r_dout;
        assign w_vld_all[gi]                           = r_vld;
    end

    assign t1.t1_doutB = w_dout_all;
    assign t1.t1_vldB  = w_vld_all;

endmodule

// File: tb/tb_algo_4cor1a_c40_t1_mem_resp.sv
// Randomised and directed checks of the T1 memory responder against a queue-based
// model of the masked-write / fixed-latency-read behaviour.
module tb_algo_4cor1a_c40_t1_mem_resp;
    localparam int N = 4;
    localparam int R = 2048;
    localparam int B = 11;
    localparam int W = 73;
    localparam int D = 3;
    localparam logic [W-1:0] ALL1 = {W{1'b1}};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    algo_4cor1a_c40_t1_mem_resp_if #(.NUMCTPT(N), .T1_BITSROW(B), .T1_PHYWDTH(W)) t1_bus();

    algo_4cor1a_c40_t1_mem_resp #(
        .NUMCTPT(N), .T1_NUMSROW(R), .T1_BITSROW(B), .T1_PHYWDTH(W), .T1_DELAY(D)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .t1  (t1_bus)
    );

    // stimulus for the upcoming edge
    logic [N-1:0] we, re;
    logic [B-1:0] a_a [N];
    logic [B-1:0] a_b [N];
    logic [W-1:0] din [N];
    logic [W-1:0] bw  [N];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit count_full = 0;
    int full_cnt   = 0;

    // reference model: sparse memory plus a list of scheduled deliveries
    typedef struct {
        int           due;
        int           bank;
        logic [W-1:0] data;
        bit           known;
    } pend_t;
    pend_t        pend[$];
    logic [W-1:0] mdl [int];
    bit           mknown [int];
    logic [W-1:0] exp_dout [N];
    bit           exp_dk [N];
    logic [N-1:0] exp_vld;

    function automatic logic [W-1:0] mrd(int key);
        if (mdl.exists(key)) return mdl[key];
        return '0;
    endfunction

    function automatic bit mkn(int key);
`ifdef ALGO_4COR1A_C40_T1_INIT_EN
        return 1'b1;
`else
        return mknown.exists(key);
`endif
    endfunction

    task automatic clear_in();
        we = '0;
        re = '0;
        for (int b = 0; b < N; b++) begin
            a_a[b] = '0; a_b[b] = '0; din[b] = '0; bw[b] = '0;
        end
    endtask

    task automatic drive();
        t1_bus.t1_writeA = we;
        t1_bus.t1_readB  = re;
        for (int b = 0; b < N; b++) begin
            t1_bus.t1_addrA[b*B +: B] = a_a[b];
            t1_bus.t1_addrB[b*B +: B] = a_b[b];
            t1_bus.t1_dinA[b*W +: W]  = din[b];
            t1_bus.t1_bwA[b*W +: W]   = bw[b];
        end
    endtask

    task automatic model_edge();
        cyc++;
        exp_vld = '0;
        if (rst) begin
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].due == cyc) begin
                    exp_vld[pend[i].bank]  = 1'b1;
                    exp_dout[pend[i].bank] = pend[i].data;
                    exp_dk[pend[i].bank]   = pend[i].known;
                    pend.delete(i);
                end
            end
            for (int b = 0; b < N; b++) begin
                if (re[b]) begin
                    pend_t p;
                    p.due   = cyc + D;
                    p.bank  = b;
                    p.data  = mrd(b*R + int'(a_b[b]));
                    p.known = mkn(b*R + int'(a_b[b]));
                    pend.push_back(p);
                end
            end
            for (int b = 0; b < N; b++) begin
                int key;
                key = b*R + int'(a_a[b]);
                if (we[b] && bw[b] != '0) begin
                    mdl[key] = (mrd(key) & ~bw[b]) | (din[b] & bw[b]);
                    if (bw[b] == ALL1) mknown[key] = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs(string tag);
        checks++;
        assert (t1_bus.t1_vldB === exp_vld)
        else begin
            errors++;
            $error("FAIL %s vld got=%b want=%b", tag, t1_bus.t1_vldB, exp_vld);
        end
        for (int b = 0; b < N; b++) begin
            if (exp_dk[b]) begin
                checks++;
                assert (t1_bus.t1_doutB[b*W +: W] === exp_dout[b])
                else begin
                    errors++;
                    $error("FAIL %s dout[%0d] got=%h want=%h", tag, b, t1_bus.t1_doutB[b*W +: W], exp_dout[b]);
                end
            end
        end
    endtask

    task automatic step(string tag);
        drive();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
        if (count_full && t1_bus.t1_vldB == 4'hF) full_cnt++;
        $display("cyc=%0d %s rst=%b vld=%b", cyc, tag, rst, t1_bus.t1_vldB);
        clear_in();
    endtask

    task automatic idle(string tag, int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic assert_reset(string tag);
        @(negedge clk);
        rst = 1'b0;
        #1;
        pend.delete();
        exp_vld = '0;
        for (int b = 0; b < N; b++) begin
            exp_dout[b] = '0;
            exp_dk[b]   = 1'b1;
        end
`ifdef ALGO_4COR1A_C40_T1_INIT_EN
        mdl.delete();
        mknown.delete();
`endif
        check_outputs(tag);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        clear_in();
        drive();
        exp_vld = '0;
        for (int b = 0; b < N; b++) begin
            exp_dout[b] = '0;
            exp_dk[b]   = 1'b1;
        end

        // reset state, with traffic that must be ignored
        we[0] = 1'b1; a_a[0] = 11'd9; din[0] = ALL1; bw[0] = ALL1; re = 4'hF;
        step("reset_hold");
        idle("reset_hold", 2);
        release_reset();

        // single access on bank 2
        we[2] = 1'b1; a_a[2] = 11'h155; din[2] = ALL1; bw[2] = ALL1;
        step("single_wr");
        re[2] = 1'b1; a_b[2] = 11'h155;
        step("single_rd");
        idle("single_wait", D);

        // bit-write mask on bank 0
        we[0] = 1'b1; a_a[0] = 11'd5; din[0] = '0; bw[0] = ALL1;
        step("mask_clr");
        we[0] = 1'b1; a_a[0] = 11'd5; din[0] = ALL1; bw[0] = 73'h0FF;
        step("mask_wr");
        re[0] = 1'b1; a_b[0] = 11'd5;
        step("mask_rd");
        idle("mask_wait", D);

        // read-before-write collision on bank 1
        we[1] = 1'b1; a_a[1] = 11'd7; din[1] = 73'hA5; bw[1] = ALL1;
        step("rbw_pre");
        we[1] = 1'b1; a_a[1] = 11'd7; din[1] = 73'h5A; bw[1] = ALL1;
        re[1] = 1'b1; a_b[1] = 11'd7;
        step("rbw_coll");
        re[1] = 1'b1; a_b[1] = 11'd7;
        step("rbw_next");
        idle("rbw_wait", D);

        // full throughput: preload row r with r, then read rows 0..15 every cycle
        for (int r = 0; r < 16; r++) begin
            we = 4'hF;
            for (int b = 0; b < N; b++) begin
                a_a[b] = B'(r); din[b] = W'(r); bw[b] = ALL1;
            end
            step("tput_load");
        end
        count_full = 1'b1;
        for (int r = 0; r < 16; r++) begin
            re = 4'hF;
            for (int b = 0; b < N; b++) a_b[b] = B'(r);
            step("tput_rd");
        end
        idle("tput_wait", D);
        count_full = 1'b0;
        checks++;
        assert (full_cnt == 16)
        else begin
            errors++;
            $error("FAIL tput_count got=%0d want=16", full_cnt);
        end

        // mid-pipeline reset discards in-flight reads
        re = 4'hF;
        for (int b = 0; b < N; b++) a_b[b] = 11'd3;
        step("midrst_rd");
        assert_reset("midrst_now");
        we = 4'hF; re = 4'hF;
        for (int b = 0; b < N; b++) begin
            a_a[b] = 11'd2; din[b] = ALL1; bw[b] = ALL1; a_b[b] = 11'd4;
        end
        step("midrst_hold");
        idle("midrst_hold", D);
        release_reset();
        re[1] = 1'b1; a_b[1] = 11'd2;
        step("midrst_after");
        idle("midrst_wait", D);

        // unwritten row read
        re[3] = 1'b1; a_b[3] = 11'h7FF;
        step("unwritten_rd");
        idle("unwritten_wait", D);

        // randomised traffic over a small row window, with one reset in the middle
        for (int i = 0; i < 200; i++) begin
            if (i == 100) begin
                assert_reset("rand_rst");
                idle("rand_rst_hold", 2);
                release_reset();
            end
            for (int b = 0; b < N; b++) begin
                int sel;
                we[b]  = 1'($urandom_range(0, 1));
                re[b]  = 1'($urandom_range(0, 1));
                a_a[b] = B'($urandom_range(0, 15));
                a_b[b] = B'($urandom_range(0, 15));
                din[b] = {$urandom, $urandom, $urandom};
                sel    = $urandom_range(0, 3);
                bw[b]  = (sel == 0) ? '0 : (sel == 1) ? ALL1 : {$urandom, $urandom, $urandom};
            end
            step("rand");
        end
        idle("rand_drain", D + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end
endmodule
